// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and parameter check for the clock monitor
package clk_mon_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, HIGH, LOW} clk_mon_state_t;

  // The expected period must split into two equal phases of at least one cycle.
  function automatic bit params_ok(input int exp_pd);
    return (exp_pd >= 2) && ((exp_pd % 2) == 0);
  endfunction

endpackage

// File: rtl/clk_monitor_if.sv
// rtl/clk_monitor_if.sv - control and measurement bundle of the clock monitor
interface clk_monitor_if #(
  parameter int W = 16
);
  logic         en;
  logic         sig_in;
  logic [W-1:0] high_time;
  logic [W-1:0] low_time;
  logic [W:0]   period;
  logic         valid;
  logic         pd_err;
  logic         duty_err;
  logic         ovf;

  modport master (
    output en, sig_in,
    input  high_time, low_time, period, valid, pd_err, duty_err, ovf
  );

  modport slave (
    input  en, sig_in,
    output high_time, low_time, period, valid, pd_err, duty_err, ovf
  );
endinterface

// File: rtl/clk_monitor_sync_edge.sv
// rtl/clk_monitor_sync_edge.sv - two-flop synchronizer with edge detect
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  // Resynchronize the asynchronous level and keep one delayed copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign s    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - period and duty monitor for an asynchronous square wave
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int W      = 16,
  parameter int EXP_PD = 10,
  parameter int TOL    = 0
) (
  input logic          clk,
  input logic          rst,
  clk_monitor_if.slave bus
);
  if (!params_ok(EXP_PD)) begin : g_bad_param
    $fatal(1, "clk_monitor: EXP_PD must be even and >= 2");
  end

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [31:0]  PD_MAX  = 32'(EXP_PD + TOL);
  localparam logic [31:0]  PD_MIN  = 32'(EXP_PD);
  localparam logic [31:0]  TOL_W   = 32'(TOL);

  clk_mon_state_t state;
  logic           s, rise, fall;
  logic [W-1:0]   hi_cnt, lo_cnt;
  logic [W-1:0]   high_time, low_time;
  logic [W:0]     period, sum;
  logic [31:0]    sum_ext;
  logic           valid, pd_err, duty_err, ovf, pd_bad;

  sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sig_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // Period of the phase pair being closed; compared in 32 bits so the
  // lower-bound test cannot underflow.
  always_comb begin
    sum     = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    sum_ext = 32'(sum);
    pd_bad  = (sum_ext > PD_MAX) || ((sum_ext + TOL_W) < PD_MIN);
  end

  // Measurement FSM: count high and low phases, publish on each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      valid     <= 1'b0;
      pd_err    <= 1'b0;
      duty_err  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid    <= 1'b0;
      pd_err   <= 1'b0;
      duty_err <= 1'b0;
      ovf      <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ARM;
          // A high phase already in progress is of unknown length; skip it.
          ARM: if (!s) state <= WAIT_RISE;
          WAIT_RISE: begin
            if (rise) begin
              hi_cnt <= W'(1);
              state  <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              lo_cnt <= W'(1);
              state  <= LOW;
            end else if (s) begin
              if (hi_cnt == CNT_MAX) begin
                ovf   <= 1'b1;
                state <= ARM;
              end else begin
                hi_cnt <= hi_cnt + 1'b1;
              end
            end
          end
          LOW: begin
            if (rise) begin
              high_time <= hi_cnt;
              low_time  <= lo_cnt;
              period    <= sum;
              valid     <= 1'b1;
              pd_err    <= pd_bad;
              duty_err  <= (hi_cnt != lo_cnt);
              hi_cnt    <= W'(1);
              state     <= HIGH;
            end else if (!s) begin
              if (lo_cnt == CNT_MAX) begin
                ovf   <= 1'b1;
                state <= ARM;
              end else begin
                lo_cnt <= lo_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.high_time = high_time;
  assign bus.low_time  = low_time;
  assign bus.period    = period;
  assign bus.valid     = valid;
  assign bus.pd_err    = pd_err;
  assign bus.duty_err  = duty_err;
  assign bus.ovf       = ovf;
endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - directed self-checking bench for clk_monitor
module tb_clk_monitor;
  import clk_mon_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sig = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ps[8];
  int vc[3], fh[3], fl[3], lh[3], ll[3], lp[3], pe_cnt[3], de_cnt[3];
  int bad[3], ovc[3], ov_cyc[3], fv_cyc[3], lv_cyc[3], gap[3];

  always #5 clk = ~clk;

  clk_monitor_if #(.W(16)) b0 ();
  clk_monitor_if #(.W(16)) b1 ();
  clk_monitor_if #(.W(4))  b2 ();

  assign b0.en = en;  assign b0.sig_in = sig;
  assign b1.en = en;  assign b1.sig_in = sig;
  assign b2.en = en;  assign b2.sig_in = sig;

  clk_monitor #(.W(16), .EXP_PD(10), .TOL(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  clk_monitor #(.W(16), .EXP_PD(10), .TOL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  clk_monitor #(.W(4),  .EXP_PD(10), .TOL(0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic clear_cap();
    for (int i = 0; i < 3; i++) begin
      vc[i] = 0; fh[i] = 0; fl[i] = 0; lh[i] = 0; ll[i] = 0; lp[i] = 0;
      pe_cnt[i] = 0; de_cnt[i] = 0; bad[i] = 0; ovc[i] = 0; ov_cyc[i] = 0;
      fv_cyc[i] = 0; lv_cyc[i] = 0; gap[i] = 0;
    end
  endtask

  task automatic capture(input int i, input logic v, input int h, input int l, input int p,
                         input logic pe, input logic de, input logic o);
    if (v === 1'b1) begin
      if (vc[i] == 0) begin fv_cyc[i] = cyc; fh[i] = h; fl[i] = l; end
      else gap[i] = cyc - lv_cyc[i];
      lv_cyc[i] = cyc;
      vc[i]++;
      lh[i] = h; ll[i] = l; lp[i] = p;
      if (pe === 1'b1) pe_cnt[i]++;
      if (de === 1'b1) de_cnt[i]++;
    end else if (pe === 1'b1 || de === 1'b1) begin
      bad[i]++;
    end
    if (o === 1'b1) begin ovc[i]++; ov_cyc[i] = cyc; end
  endtask

  // One sampled cycle: observe outputs away from the edge, then drive sig_in.
  task automatic step(input logic v);
    @(negedge clk);
    cyc++;
    capture(0, b0.valid, int'(b0.high_time), int'(b0.low_time), int'(b0.period), b0.pd_err, b0.duty_err, b0.ovf);
    capture(1, b1.valid, int'(b1.high_time), int'(b1.low_time), int'(b1.period), b1.pd_err, b1.duty_err, b1.ovf);
    capture(2, b2.valid, int'(b2.high_time), int'(b2.low_time), int'(b2.period), b2.pd_err, b2.duty_err, b2.ovf);
    sig = v;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      if (p < 8) ps[p] = cyc + 1;
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    step(v);
    step(v);
    rst = 1'b0;
    clear_cap();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    repeat (3) step(1'b0);
    vectors++; if (b0.high_time !== 16'd0) begin miscompares++; $display("FAIL reset_high_time got %0d want 0", b0.high_time); end
    vectors++; if (b0.low_time !== 16'd0) begin miscompares++; $display("FAIL reset_low_time got %0d want 0", b0.low_time); end
    vectors++; if (b0.period !== 17'd0) begin miscompares++; $display("FAIL reset_period got %0d want 0", b0.period); end
    vectors++; if (b0.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", b0.valid); end
    vectors++; if ({b0.pd_err, b0.duty_err, b0.ovf} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {b0.pd_err, b0.duty_err, b0.ovf}); end
    vectors++; if (dut0.state !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d want IDLE", dut0.state); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    en = 1'b1;
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(5, 5, 4);
    repeat (4) step(1'b0);
    vectors++; if (vc[0] !== 3) begin miscompares++; $display("FAIL nom_valid_count got %0d want 3", vc[0]); end
    vectors++; if (fh[0] !== 5 || fl[0] !== 5) begin miscompares++; $display("FAIL nom_first got %0d/%0d want 5/5", fh[0], fl[0]); end
    vectors++; if (lp[0] !== 10) begin miscompares++; $display("FAIL nom_period got %0d want 10", lp[0]); end
    vectors++; if (pe_cnt[0] !== 0 || de_cnt[0] !== 0) begin miscompares++; $display("FAIL nom_errs got pd=%0d duty=%0d want 0/0", pe_cnt[0], de_cnt[0]); end
    vectors++; if (fv_cyc[0] !== ps[1] + 3) begin miscompares++; $display("FAIL nom_latency got %0d want %0d", fv_cyc[0], ps[1] + 3); end
    vectors++; if (gap[0] !== 10) begin miscompares++; $display("FAIL nom_spacing got %0d want 10", gap[0]); end
    vectors++; if (bad[0] !== 0) begin miscompares++; $display("FAIL nom_unqualified_err got %0d want 0", bad[0]); end
    vectors++; if (pe_cnt[1] !== 0 || vc[1] !== 3) begin miscompares++; $display("FAIL nom_tol1 got pd=%0d vc=%0d want 0/3", pe_cnt[1], vc[1]); end
  endtask

  task automatic test_duty();
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(3, 7, 3);
    repeat (4) step(1'b0);
    vectors++; if (vc[0] !== 2) begin miscompares++; $display("FAIL duty_valid_count got %0d want 2", vc[0]); end
    vectors++; if (lh[0] !== 3 || ll[0] !== 7 || lp[0] !== 10) begin miscompares++; $display("FAIL duty_values got %0d/%0d/%0d want 3/7/10", lh[0], ll[0], lp[0]); end
    vectors++; if (de_cnt[0] !== 2 || pe_cnt[0] !== 0) begin miscompares++; $display("FAIL duty_flags got duty=%0d pd=%0d want 2/0", de_cnt[0], pe_cnt[0]); end
  endtask

  task automatic test_tolerance();
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(6, 6, 3);
    repeat (4) step(1'b0);
    vectors++; if (lp[1] !== 12 || vc[1] !== 2) begin miscompares++; $display("FAIL tol12_period got %0d vc=%0d want 12 vc=2", lp[1], vc[1]); end
    vectors++; if (pe_cnt[1] !== 2 || de_cnt[1] !== 0) begin miscompares++; $display("FAIL tol12_flags got pd=%0d duty=%0d want 2/0", pe_cnt[1], de_cnt[1]); end
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(6, 5, 3);
    repeat (4) step(1'b0);
    vectors++; if (lh[1] !== 6 || ll[1] !== 5 || lp[1] !== 11) begin miscompares++; $display("FAIL tol11_values got %0d/%0d/%0d want 6/5/11", lh[1], ll[1], lp[1]); end
    vectors++; if (pe_cnt[1] !== 0 || de_cnt[1] !== 2) begin miscompares++; $display("FAIL tol11_flags got pd=%0d duty=%0d want 0/2", pe_cnt[1], de_cnt[1]); end
    vectors++; if (pe_cnt[0] !== 2) begin miscompares++; $display("FAIL tol0_p11 got pd=%0d want 2", pe_cnt[0]); end
  endtask

  task automatic test_overflow();
    int a;
    do_reset(1'b0);
    repeat (4) step(1'b0);
    a = cyc + 1;
    repeat (22) step(1'b1);
    vectors++; if (ovc[2] !== 1) begin miscompares++; $display("FAIL ovf_count got %0d want 1", ovc[2]); end
    vectors++; if (ov_cyc[2] !== a + 18) begin miscompares++; $display("FAIL ovf_time got %0d want %0d", ov_cyc[2], a + 18); end
    vectors++; if (vc[2] !== 0) begin miscompares++; $display("FAIL ovf_no_valid got %0d want 0", vc[2]); end
    vectors++; if (dut2.state !== ARM) begin miscompares++; $display("FAIL ovf_state got %0d want ARM", dut2.state); end
    vectors++; if (ovc[0] !== 0) begin miscompares++; $display("FAIL ovf_wide got %0d want 0", ovc[0]); end
    repeat (4) step(1'b0);
    wave(5, 5, 3);
    repeat (4) step(1'b0);
    vectors++; if (vc[2] !== 2 || lh[2] !== 5 || ll[2] !== 5) begin miscompares++; $display("FAIL ovf_recover got vc=%0d %0d/%0d want 2 5/5", vc[2], lh[2], ll[2]); end
  endtask

  task automatic test_enable_high();
    en = 1'b0;
    do_reset(1'b1);
    repeat (4) step(1'b1);
    en = 1'b1;
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    wave(5, 5, 3);
    repeat (4) step(1'b0);
    vectors++; if (vc[0] !== 2) begin miscompares++; $display("FAIL partial_count got %0d want 2", vc[0]); end
    vectors++; if (fh[0] !== 5 || fl[0] !== 5) begin miscompares++; $display("FAIL partial_first got %0d/%0d want 5/5", fh[0], fl[0]); end
  endtask

  task automatic test_en_abort();
    en = 1'b1;
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(5, 5, 3);
    repeat (4) step(1'b1);
    en = 1'b0;
    repeat (2) step(1'b1);
    repeat (5) step(1'b0);
    vectors++; if (vc[0] !== 3) begin miscompares++; $display("FAIL abort_count got %0d want 3", vc[0]); end
    vectors++; if (b0.high_time !== 16'd5 || b0.period !== 17'd10) begin miscompares++; $display("FAIL abort_hold got %0d/%0d want 5/10", b0.high_time, b0.period); end
    en = 1'b1;
    repeat (4) step(1'b0);
    wave(5, 5, 3);
    repeat (4) step(1'b0);
    vectors++; if (vc[0] !== 5 || lh[0] !== 5 || ll[0] !== 5) begin miscompares++; $display("FAIL abort_resume got vc=%0d %0d/%0d want 5 5/5", vc[0], lh[0], ll[0]); end
  endtask

  task automatic test_rst_abort();
    do_reset(1'b0);
    repeat (4) step(1'b0);
    wave(5, 5, 2);
    repeat (6) step(1'b1);
    vectors++; if (vc[0] !== 2) begin miscompares++; $display("FAIL rst_pre_count got %0d want 2", vc[0]); end
    rst = 1'b1; en = 1'b0;
    repeat (2) step(1'b1);
    vectors++; if (b0.high_time !== 16'd0 || b0.low_time !== 16'd0 || b0.period !== 17'd0) begin miscompares++; $display("FAIL rst_mid_values got %0d/%0d/%0d want 0/0/0", b0.high_time, b0.low_time, b0.period); end
    vectors++; if ({b0.valid, b0.pd_err, b0.duty_err, b0.ovf} !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_flags got %b want 0000", {b0.valid, b0.pd_err, b0.duty_err, b0.ovf}); end
    repeat (3) step(1'b0);
    rst = 1'b0;
    clear_cap();
    repeat (2) step(1'b0);
    en = 1'b1;
    repeat (4) step(1'b0);
    wave(5, 5, 3);
    repeat (4) step(1'b0);
    vectors++; if (vc[0] !== 2 || lh[0] !== 5 || ll[0] !== 5 || lp[0] !== 10) begin miscompares++; $display("FAIL rst_resume got vc=%0d %0d/%0d/%0d want 2 5/5/10", vc[0], lh[0], ll[0], lp[0]); end
  endtask

  initial begin
    clear_cap();
    test_reset();
    test_nominal();
    test_duty();
    test_tolerance();
    test_overflow();
    test_enable_high();
    test_en_abort();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
